ack_bus_sched: RTL and testbench
================================

// Module: ack_bus_sched
// PURPOSE
//   Clocked, parametrised ACK-bus arbiter. Successor to the 4-source combinational wired-AND ACK arbiter.
//   Serves N_SRC requesters (MEM/SHA/AES/CTRL today, more later) with fixed-priority or round-robin selection.
//   Holds a grant until the winner signals done, drops its request, or a timeout fires.
//   Sits between the crypto/memory engines and the control ACK path; broadcasts the winner ID and a grant event.
// PARAMETERS
//   N_SRC        4   number of requesters, >= 2; source i has ID i
//   ID_W         $clog2(N_SRC)   width of winner ID (derived, do not override)
//   MODE         0   0 = fixed priority (lowest ID wins, wired-AND equivalent); 1 = round-robin
//   TIMEOUT_CYC  64  max cycles a grant may be held; 0 disables timeout
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   req_i        in   N_SRC  level request per source, bit i = source ID i
//   done_i       in   1      winner finished; sampled only in GRANT state
//   grant_o      out  N_SRC  one-hot grant (ACK READY) to the winner, registered
//   winner_id_o  out  ID_W   ID of current/last winner, registered
//   ack_event_o  out  1      one-cycle pulse on the first cycle grant_o is asserted
//   busy_o       out  1      high while in GRANT state
//   timeout_o    out  1      one-cycle pulse when a grant is force-released by timeout
// BEHAVIOUR
//   Reset (async assert):
//     - grant_o=0, winner_id_o=0, ack_event_o=0, busy_o=0, timeout_o=0
//     - state=IDLE, rr_ptr=0, hold_cnt=0
//     - Mid-grant reset drops the grant immediately, with no event/timeout pulse.
//   FSM IDLE:
//     - If |req_i, pick winner W.
//     - Next edge: grant_o=1<<W, winner_id_o=W, ack_event_o=1, hold_cnt=0, ->GRANT.
//     - Latency from req_i sampled high to grant_o high: 1 cycle.
//     - If no request, outputs other than winner_id_o stay 0; winner_id_o holds its last value.
//   FSM GRANT, evaluated every edge in this priority order:
//     a) done_i=1 -> release.
//     b) req_i[W]=0 (requester abort) -> release.
//     c) TIMEOUT_CYC!=0 && hold_cnt==TIMEOUT_CYC-1 -> release with timeout_o=1 for one cycle.
//     d) otherwise hold_cnt++ and the grant is held.
//     - done_i and timeout in the same cycle: done wins, no timeout pulse.
//     - Release: grant_o=0, busy_o=0, ->IDLE. In MODE=1, rr_ptr=(W+1) mod N_SRC (wrap at N_SRC-1 -> 0).
//     - Minimum of one IDLE cycle between consecutive grants; back-to-back requests see a 1-cycle bubble.
//   Winner selection (combinational over req_i):
//     - MODE=0: lowest set index.
//     - MODE=1: first set index scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_SRC.
//     - Requests arriving during GRANT wait; they are not latched and must remain asserted.
//   Widths:
//     - hold_cnt is $clog2(TIMEOUT_CYC+1) bits and saturates, never wraps.
//     - rr_ptr is ID_W bits; arithmetic is explicitly modulo N_SRC (non-power-of-2 N_SRC legal).
//   Invariants: grant_o is one-hot or zero; ack_event_o implies busy_o; busy_o == (grant_o!=0).
// STRUCTURE
//   Shared package ack_bus_pkg:
//     - ACK_MODE_FIXED=0, ACK_MODE_RR=1
//     - state encoding ACK_IDLE/ACK_GRANT
//     - legacy IDs ID_MEM=0, ID_SHA=1, ID_AES=2, ID_CTRL=3
//   Sub-module ack_rr_pick: combinational rotating-priority picker.
//     - Inputs: req, ptr, mode. Outputs: valid, idx.
//     - Instantiated once; the FSM, counter and registers live in ack_bus_sched.
// TESTING
//   1. N_SRC=4, MODE=0: req_i=4'b1010 -> 1 cycle later grant_o=4'b0010, winner_id_o=1, one ack_event_o pulse; done_i -> grant_o=0 next cycle.
//   2. MODE=1, all four req held, done_i pulsed each grant -> winners 0,1,2,3,0 with a 1-cycle IDLE gap between each.
//   3. TIMEOUT_CYC=8, req_i=4'b0100 held, done_i=0 -> grant_o=4'b0100 for exactly 8 cycles, then timeout_o pulse and grant_o=0.
//   4. Same cycle done_i=1 and hold_cnt==TIMEOUT_CYC-1 -> release, timeout_o stays 0.
//   5. Winner drops req mid-grant (req_i 4'b1000->4'b0000) -> grant_o=0 next cycle, no timeout_o; rst asserted mid-grant -> all outputs 0 immediately, next grant after reset goes to ID 0 in MODE=1.
//   6. N_SRC=5, MODE=1, winner ID 4 released -> rr_ptr wraps to 0; req_i=5'b10001 -> next winner ID 0.

Source files
------------

// File: rtl/ack_bus_pkg.sv
// Shared constants for the ACK-bus scheduler: arbitration modes, FSM state
// encoding and the legacy requester IDs.
package ack_bus_pkg;

    localparam logic ACK_MODE_FIXED = 1'b0;
    localparam logic ACK_MODE_RR    = 1'b1;

    localparam logic [0:0] ACK_IDLE  = 1'b0;
    localparam logic [0:0] ACK_GRANT = 1'b1;

    localparam int ID_MEM  = 0;
    localparam int ID_SHA  = 1;
    localparam int ID_AES  = 2;
    localparam int ID_CTRL = 3;

endpackage

// File: rtl/ack_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// scanning from ptr (round-robin) or from index 0 (fixed priority).
module ack_rr_pick
    import ack_bus_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    int base;
    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        base  = (mode == ACK_MODE_RR) ? int'(ptr) : 0;
        if (base >= N_SRC) base = 0;
        // Scan from the far end so the last hit written is the nearest to base.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            j = base + k;
            if (j >= N_SRC) j = j - N_SRC;
            if (req[j]) begin
                valid = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/ack_bus_sched.sv
// Clocked ACK-bus arbiter: grants one requester at a time and holds the grant
// until done, requester abort or timeout; one IDLE cycle between grants.
module ack_bus_sched
    import ack_bus_pkg::*;
#(
    parameter  int N_SRC       = 4,
    parameter  int MODE        = 0,
    parameter  int TIMEOUT_CYC = 64,
    localparam int ID_W        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req_i,
    input  logic             done_i,
    output logic [N_SRC-1:0] grant_o,
    output logic [ID_W-1:0]  winner_id_o,
    output logic             ack_event_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic MODE_BIT = (MODE == 1) ? ACK_MODE_RR : ACK_MODE_FIXED;

    logic [0:0]       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  winner_q, winner_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             release_now;

    ack_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .mode  (MODE_BIT),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        winner_d    = winner_q;
        ack_d       = 1'b0;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        release_now = 1'b0;

        if (state_q == ACK_IDLE) begin
            if (pick_valid) begin
                state_d    = ACK_GRANT;
                grant_d    = N_SRC'(1) << pick_idx;
                winner_d   = pick_idx;
                ack_d      = 1'b1;
                hold_cnt_d = '0;
            end
        end else begin
            // done beats abort beats timeout, so a same-edge done never pulses timeout
            if (done_i || !req_i[winner_q]) begin
                release_now = 1'b1;
            end else if (TIMEOUT_CYC != 0 && hold_cnt_q == CNT_LAST) begin
                release_now = 1'b1;
                timeout_d   = 1'b1;
            end else if (hold_cnt_q != '1) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end

            if (release_now) begin
                state_d = ACK_IDLE;
                grant_d = '0;
                if (MODE_BIT == ACK_MODE_RR)
                    rr_ptr_d = (winner_q == ID_W'(N_SRC - 1)) ? '0 : winner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACK_IDLE;
            grant_q    <= '0;
            winner_q   <= '0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            winner_q   <= winner_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_o     = grant_q;
    assign winner_id_o = winner_q;
    assign ack_event_o = ack_q;
    assign busy_o      = (state_q == ACK_GRANT);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_ack_bus_sched.sv
// Directed bench for ack_bus_sched: fixed-priority table, round-robin rotation,
// timeout boundary, abort, mid-grant reset and non-power-of-2 pointer wrap.
module tb_ack_bus_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // d0: N=4 fixed priority, TIMEOUT 8
    logic [3:0] req0 = '0;
    logic       done0 = 1'b0;
    logic [3:0] g0;
    logic [1:0] id0;
    logic       ack0, busy0, to0;

    // d1: N=4 round-robin, TIMEOUT 8
    logic [3:0] req1 = '0;
    logic       done1 = 1'b0;
    logic [3:0] g1;
    logic [1:0] id1;
    logic       ack1, busy1, to1;

    // d2: N=5 round-robin, default TIMEOUT
    logic [4:0] req2 = '0;
    logic       done2 = 1'b0;
    logic [4:0] g2;
    logic [2:0] id2;
    logic       ack2, busy2, to2;

    ack_bus_sched #(.N_SRC(4), .MODE(0), .TIMEOUT_CYC(8)) d0 (
        .clk(clk), .rst(rst), .req_i(req0), .done_i(done0), .grant_o(g0),
        .winner_id_o(id0), .ack_event_o(ack0), .busy_o(busy0), .timeout_o(to0));

    ack_bus_sched #(.N_SRC(4), .MODE(1), .TIMEOUT_CYC(8)) d1 (
        .clk(clk), .rst(rst), .req_i(req1), .done_i(done1), .grant_o(g1),
        .winner_id_o(id1), .ack_event_o(ack1), .busy_o(busy1), .timeout_o(to1));

    ack_bus_sched #(.N_SRC(5), .MODE(1), .TIMEOUT_CYC(64)) d2 (
        .clk(clk), .rst(rst), .req_i(req2), .done_i(done2), .grant_o(g2),
        .winner_id_o(id2), .ack_event_o(ack2), .busy_o(busy2), .timeout_o(to2));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic a, input logic b, input logic t);
        chk({tag, " grant"},   int'(g0),    int'(g));
        chk({tag, " id"},      int'(id0),   int'(id));
        chk({tag, " ack"},     int'(ack0),  int'(a));
        chk({tag, " busy"},    int'(busy0), int'(b));
        chk({tag, " timeout"}, int'(to0),   int'(t));
    endtask

    task automatic chk1(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic a, input logic b, input logic t);
        chk({tag, " grant"},   int'(g1),    int'(g));
        chk({tag, " id"},      int'(id1),   int'(id));
        chk({tag, " ack"},     int'(ack1),  int'(a));
        chk({tag, " busy"},    int'(busy1), int'(b));
        chk({tag, " timeout"}, int'(to1),   int'(t));
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] id;
        logic       ack;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[11];
    int   gcnt;

    initial begin
        // fixed-priority vectors: inputs applied, then outputs after the edge
        tbl[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4'b0110, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        step();
        step();
        chk0("reset d0", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk1("reset d1", 4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset d2 grant", int'(g2), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            req0  = tbl[i].req;
            done0 = tbl[i].done;
            step();
            chk0($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].ack, tbl[i].busy, tbl[i].to);
        end

        // timeout: grant visible for exactly 8 cycles, then a timeout pulse
        req0 = 4'b0100;
        done0 = 1'b0;
        gcnt = 0;
        step();
        chk0("to grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        while (g0 == 4'b0100 && gcnt < 20) begin
            gcnt++;
            step();
        end
        chk("to held cycles", gcnt, 8);
        chk0("to release", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk0("to regrant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);

        // done on the timeout edge: release with no timeout pulse
        for (int i = 0; i < 7; i++) step();
        chk0("pre-boundary", 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
        done0 = 1'b1;
        step();
        chk0("done at boundary", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
        done0 = 1'b0;
        req0 = 4'b0000;

        // round-robin rotation with one IDLE cycle between grants
        req1 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            done1 = 1'b0;
            step();
            chk1($sformatf("rr grant%0d", k), eg, 2'(k % 4), 1'b1, 1'b1, 1'b0);
            done1 = 1'b1;
            step();
            chk1($sformatf("rr gap%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0, 1'b0);
        end
        // pointer now 1: requester abort of winner 3
        done1 = 1'b0;
        req1 = 4'b1000;
        step();
        chk1("abort grant", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
        req1 = 4'b0000;
        step();
        chk1("abort release", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);

        // pointer now 0; grant 0, release, grant 1, then reset mid-grant
        req1 = 4'b1111;
        step();
        chk1("pre-rst g0", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        step();
        chk1("pre-rst g1", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);

        // N=5 wrap: 1 -> ptr 2 -> winner 4 -> ptr wraps to 0 -> winner 0
        req2 = 5'b00010;
        step();
        chk("n5 w1 id", int'(id2), 1);
        done2 = 1'b1;
        step();
        done2 = 1'b0;
        req2 = 5'b10001;
        step();
        chk("n5 w4 id", int'(id2), 4);
        chk("n5 w4 grant", int'(g2), 5'b10000);
        done2 = 1'b1;
        step();
        chk("n5 release", int'(busy2), 0);
        done2 = 1'b0;
        step();
        chk("n5 wrap id", int'(id2), 0);
        chk("n5 wrap grant", int'(g2), 5'b00001);
        chk("n5 wrap ack", int'(ack2), 1);

        // d1 still granting 1 since req held; async reset clears at once
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("mid-grant rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk1("post-rst grant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
